// File: rtl/spi_inert_mstr_if.sv
// spi_inert_mstr_if
//   Groups the inertial-interface handshake (wrt/cmd/done/rd_data) with the
//   four SPI pins of the sensor link.
//   master modport: the SPI master side (drives SS_n/SCLK/MOSI, done, rd_data)
//   slave  modport: the environment side (drives wrt, cmd and MISO)
interface spi_inert_mstr_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [7:0]  rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (input wrt, cmd, MISO, output done, rd_data, SS_n, SCLK, MOSI);
  modport slave  (output wrt, cmd, MISO, input done, rd_data, SS_n, SCLK, MOSI);
endinterface

// File: rtl/spi_inert_mstr.sv
// spi_inert_mstr
//   16-bit SPI master (mode 3, MSB first) feeding the 6-axis inertial sensor.
//   One accepted wrt runs one full-duplex frame: cmd is shifted out on MOSI and
//   the received word's low byte is returned on rd_data when done rises.
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : spi_inert_mstr_if.master
//            wrt/cmd in, done/rd_data out, SS_n/SCLK/MOSI out, MISO in
module spi_inert_mstr #(
  parameter int SCLK_DIV = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_inert_mstr_if.master        bus
);

  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] HALF    = CW'(SCLK_DIV / 2);
  localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_DIV / 2 - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRONT = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] BACK  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_bit_cnt;   // SCLK rises seen this frame, 0..16
  logic [15:0]   r_shft;
  logic          r_smpl;
  logic          r_ss_n;
  logic          r_sclk;
  logic          r_done;
  logic [15:0]   w_shft_nxt;

  assign w_shft_nxt  = {r_shft[14:0], r_smpl};

  assign bus.SS_n    = r_ss_n;
  assign bus.SCLK    = r_sclk;
  assign bus.MOSI    = r_shft[15];
  assign bus.done    = r_done;
  assign bus.rd_data = r_shft[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shft    <= '0;
      r_smpl    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.wrt) begin
            r_shft    <= bus.cmd;
            r_done    <= 1'b0;
            r_ss_n    <= 1'b0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_state   <= FRONT;
          end
        end
        // Half period of idle-high SCLK so cmd[15] is set up before the first fall.
        FRONT: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // Phase is tracked by r_sclk itself; the first fall came from FRONT,
        // so every fall issued here is fall 2..16 and carries a shift.
        SHIFT: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk    <= 1'b1;
              r_smpl    <= bus.MISO;
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end else if (r_bit_cnt == 5'd16) begin
              r_state <= BACK;          // SCLK stays high, no 17th fall
            end else begin
              r_sclk <= 1'b0;
              r_shft <= w_shft_nxt;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // Half period of SS hold time, then one edge that lands the last
        // sample, releases SS_n and flags done together.
        BACK: begin
          if (r_cnt == HALF) begin
            r_shft  <= w_shft_nxt;
            r_ss_n  <= 1'b1;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_inert_mstr.sv
// tb_spi_inert_mstr
//   Directed bench for spi_inert_mstr with a mode-3 SPI slave model.
module tb_spi_inert_mstr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_inert_mstr_if bus();

  spi_inert_mstr #(.SCLK_DIV(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int failures = 0;

  // Slave model: samples MOSI on SCLK rise, drives tx MSB first, changing on falls.
  logic [15:0] tx = 16'h0000;
  logic [15:0] rx = 16'h0000;
  logic        loopback = 1'b0;
  logic        miso_r = 1'b0;
  logic        ps_ss = 1'b1;
  logic        ps_sclk = 1'b1;
  int          rises = 0;
  int          falls = 0;

  assign bus.MISO = loopback ? bus.MOSI : miso_r;

  always @(bus.SS_n, bus.SCLK) begin
    if (!bus.SS_n && ps_ss) begin
      rises = 0;
      falls = 0;
      rx = 16'h0000;
      miso_r = tx[15];
    end else if (!bus.SS_n) begin
      if (bus.SCLK && !ps_sclk) begin
        rx = {rx[14:0], bus.MOSI};
        rises++;
      end
      if (!bus.SCLK && ps_sclk) begin
        falls++;
        if (rises < 16) miso_r = tx[15 - rises];
      end
    end
    ps_ss = bus.SS_n;
    ps_sclk = bus.SCLK;
  end

  task automatic start_frame(input logic [15:0] c);
    @(negedge clk);
    bus.cmd = c;
    bus.wrt = 1'b1;
    @(posedge clk);
    #1;
    bus.wrt = 1'b0;
  endtask

  // Returns edges counted since the caller's last sampled edge until done=1.
  task automatic wait_done(output int n, output logic last_ss);
    n = 0;
    last_ss = bus.SS_n;
    while (bus.done !== 1'b1 && n < 2000) begin
      last_ss = bus.SS_n;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.SS_n, bus.SCLK, bus.MOSI, bus.done, bus.rd_data} !== {4'b1100, 8'h00}) begin
        failures++;
        bad++;
        if (bad < 4)
          $display("FAIL reset_idle cyc=%0d got ss=%b sclk=%b mosi=%b done=%b rd=%h want 1 1 0 0 00",
                   i, bus.SS_n, bus.SCLK, bus.MOSI, bus.done, bus.rd_data);
      end
    end
  endtask

  task automatic test_tx_latency();
    int n;
    logic last_ss;
    tx = 16'h0000;
    start_frame(16'h0D02);
    checks++;
    if (bus.SS_n !== 1'b0) begin
      failures++;
      $display("FAIL ss_fall got %b want 0", bus.SS_n);
    end
    wait_done(n, last_ss);
    checks++;
    if (n != 545) begin
      failures++;
      $display("FAIL done_latency got %0d want 545", n);
    end
    checks++;
    if (bus.SS_n !== 1'b1 || last_ss !== 1'b0) begin
      failures++;
      $display("FAIL ss_rise_with_done got ss=%b prev=%b want 1 0", bus.SS_n, last_ss);
    end
    checks++;
    if (falls != 16) begin
      failures++;
      $display("FAIL sclk_falls got %0d want 16", falls);
    end
    checks++;
    if (rx !== 16'h0D02) begin
      failures++;
      $display("FAIL mosi_word got %h want 0d02", rx);
    end
  endtask

  task automatic test_rx();
    int n;
    logic last_ss;
    tx = 16'h00A5;
    start_frame(16'hA200);
    wait_done(n, last_ss);
    checks++;
    if (bus.rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL rd_data got %h want a5", bus.rd_data);
    end
    checks++;
    if (rx !== 16'hA200) begin
      failures++;
      $display("FAIL mosi_a200 got %h want a200", rx);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.rd_data !== 8'hA5 || bus.SS_n !== 1'b1) begin
      failures++;
      $display("FAIL done_hold got done=%b rd=%h ss=%b want 1 a5 1", bus.done, bus.rd_data, bus.SS_n);
    end
  endtask

  task automatic test_loopback();
    int n;
    logic last_ss;
    loopback = 1'b1;
    start_frame(16'h1462);
    wait_done(n, last_ss);
    checks++;
    if (bus.rd_data !== 8'h62) begin
      failures++;
      $display("FAIL loopback got %h want 62", bus.rd_data);
    end
    loopback = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int k;
    logic last_ss;
    tx = 16'h0033;
    start_frame(16'h0D02);
    k = 0;
    while (rises < 4 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    bus.cmd = 16'hFFFF;
    bus.wrt = 1'b1;
    @(posedge clk);
    #1;
    bus.wrt = 1'b0;
    checks++;
    if (bus.SS_n !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midframe_wrt got ss=%b done=%b want 0 0", bus.SS_n, bus.done);
    end
    wait_done(n, last_ss);
    checks++;
    if (rx !== 16'h0D02 || bus.rd_data !== 8'h33) begin
      failures++;
      $display("FAIL ignore_wrt got rx=%h rd=%h want 0d02 33", rx, bus.rd_data);
    end
    // chain: wrt on the first cycle done=1
    tx = 16'h0000;
    bus.cmd = 16'hA300;
    bus.wrt = 1'b1;
    @(posedge clk);
    #1;
    bus.wrt = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.SS_n !== 1'b0) begin
      failures++;
      $display("FAIL chain_accept got done=%b ss=%b want 0 0", bus.done, bus.SS_n);
    end
    wait_done(n, last_ss);
    checks++;
    if (n != 545 || rx !== 16'hA300 || bus.rd_data !== 8'h00) begin
      failures++;
      $display("FAIL chain_frame got n=%0d rx=%h rd=%h want 545 a300 00", n, rx, bus.rd_data);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int k;
    logic last_ss;
    tx = 16'hFFFF;
    start_frame(16'h5555);
    k = 0;
    while (rises < 7 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.SS_n, bus.SCLK, bus.done, bus.MOSI, bus.rd_data} !== {4'b1100, 8'h00}) begin
      failures++;
      $display("FAIL async_reset got ss=%b sclk=%b done=%b mosi=%b rd=%h want 1 1 0 0 00",
               bus.SS_n, bus.SCLK, bus.done, bus.MOSI, bus.rd_data);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.SS_n !== 1'b1) begin
      failures++;
      $display("FAIL no_resume got done=%b ss=%b want 0 1", bus.done, bus.SS_n);
    end
    tx = 16'h0000;
    start_frame(16'h1162);
    wait_done(n, last_ss);
    checks++;
    if (n != 545 || rx !== 16'h1162 || falls != 16) begin
      failures++;
      $display("FAIL post_reset_frame got n=%0d rx=%h falls=%0d want 545 1162 16", n, rx, falls);
    end
  endtask

  initial begin
    bus.wrt = 1'b0;
    bus.cmd = 16'h0000;
    test_reset();
    test_tx_latency();
    test_rx();
    test_loopback();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
